mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the multicycle CPU's data/instruction port. It accepts one word read or write request at a time over a valid/ready handshake, services it from an internal word array after a programmable latency, and returns a held response. It replaces the zero-handshake block RAM when bus latency or wait states must be modelled, and it lets the CPU's control unit stall on memory.

## Interface
Parameters:
- `DEPTH`, default 1024: number of 32-bit words; must be a power of two.
- `ADDR_W`, default 10: log2(DEPTH); the word index is `req_addr[ADDR_W+1:2]`.
- `LATENCY`, default 2: number of cycles from request acceptance to `resp_valid`; legal range 1..15.

Ports:
- `clk` in 1: the single clock; everything is sampled on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: the request is present.
- `req_we` in 1: 1 selects a write, 0 selects a read.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: write data.
- `req_ready` out 1: the responder can accept a request this cycle.
- `resp_valid` out 1: the response is present.
- `resp_rdata` out 32: read data; 0 for writes and for errors.
- `resp_err` out 1: the request was misaligned.
- `resp_ready` in 1: the requester takes the response.
- `req_be` in 4: byte lane enables. Present only with `MEM_RESP_BYTE_EN`.

## Operation
- The state machine has three states, IDLE, WAIT and RESP, and a 4-bit latency counter `cnt`.
- IDLE:
  - `req_ready`=1.
  - A request is accepted on an edge where `req_valid`&&`req_ready`. That edge captures `we`, the address and the data.
  - If LATENCY==1 the next state is RESP. Otherwise the next state is WAIT with `cnt`=LATENCY-2.
- WAIT:
  - `req_ready`=0.
  - If `cnt`==0 the next state is RESP. Otherwise `cnt` decrements.
- Entering RESP:
  - The array access happens on this edge.
  - A read registers `resp_rdata`=mem[idx].
  - A write commits mem[idx]=wdata and sets `resp_rdata`=0.
  - `resp_valid` goes to 1.
- RESP:
  - `resp_valid`, `resp_rdata` and `resp_err` are held stable until `resp_valid`&&`resp_ready`.
  - On that edge the next state is IDLE and `resp_valid`=0.
- Misaligned requests (`req_addr[1:0]`!=0):
  - The request is still accepted and still waits LATENCY cycles.
  - No write takes place.
  - `resp_err`=1 and `resp_rdata`=0.
- Upper address bits above ADDR_W+1 are ignored. The address wraps modulo DEPTH.
- Request inputs are ignored outside the IDLE acceptance edge, and the captured copy is used for the access.
- Array contents are not cleared by reset. Initial contents are all zero in simulation.

## Timing
- Reset values: `req_ready`=0, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0. The state is IDLE and `cnt`=0.
- `req_ready` is registered. It rises on the first edge after `reset` deasserts.
- Acceptance happens on edge k. `resp_valid` is first high after edge k+LATENCY.
- The response handshake completes on edge m. `req_ready`=1 after edge m, so the next acceptance is edge m+1 at the earliest.
- Peak throughput is one transaction per LATENCY+2 cycles.
- `resp_ready` may be held high in advance. In that case the response is consumed on the first edge after it appears.
- Reset asserted mid-transaction:
  - The transaction is aborted and every output returns to its reset value on that edge.
  - A write that has not yet reached RESP never commits.
- If a request is accepted and `reset` is asserted on the same edge, reset wins and nothing is captured.

## Configuration
- `MEM_RESP_BYTE_EN` defined:
  - The `req_be` port exists and is captured with the request.
  - A write updates only the bytes whose enable is 1. Lane i maps to bits 8i+7:8i.
  - A write with `req_be`=0 is a legal no-op that still returns a response.
  - Reads ignore `req_be`.
- `MEM_RESP_BYTE_EN` undefined:
  - No `req_be` port.
  - Every write updates all 32 bits.

## Structure
- Shared package `mem_resp_pkg` holds:
  - the state enum (IDLE, WAIT, RESP);
  - `MEM_RESP_LAT_W`=4;
  - the misalignment check as a constant function.
- Sub-module `mem_resp_array` contains the storage:
  - a single-port synchronous word array;
  - write enable, with per-byte lanes under `MEM_RESP_BYTE_EN`;
  - a registered read output.
- `mem_responder` holds the FSM, the counter, the capture registers and the response registers.

## Test plan
- Reset then idle: hold `reset`=1 for 3 cycles and release. Required: all outputs 0 during reset, `req_ready`=1 one cycle after release, `resp_valid` stays 0.
- Write then read, LATENCY=2:
  - Write 32'hDEADBEEF to address 0x10. Required: `resp_valid` 2 cycles after acceptance, `resp_rdata`=0, `resp_err`=0.
  - Read 0x10. Required: `resp_rdata`=32'hDEADBEEF.
- Backpressure: hold `resp_ready`=0 for 5 cycles after `resp_valid`. Required: the response is stable and `req_ready`=0 throughout; `req_ready`=1 exactly one cycle after the handshake.
- Misaligned write to 0x13 with data 32'h1234. Required: `resp_err`=1, and a later read of 0x10 still returns 32'hDEADBEEF.
- Address wrap, DEPTH=1024: write 32'hA5A5A5A5 to 0x1000 and read 0x0. Required: the read returns 32'hA5A5A5A5.
- Reset during WAIT, LATENCY=4:
  - Accept a write of 32'h55 to 0x20, then assert `reset` 2 cycles later. Required: no `resp_valid`, and a subsequent read of 0x20 returns the old value.
  - With `MEM_RESP_BYTE_EN`: write 32'hFFFFFFFF to 0x20 with `req_be`=4'b0101. Required: a read of 0x20 returns 32'h00FF00FF from zero contents.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared definitions for the memory responder: FSM states, counter width
// and the alignment check used when a request is captured.
package mem_resp_pkg;

    localparam int MEM_RESP_LAT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // A word access must sit on a 4-byte boundary.
    function automatic logic is_misaligned(input logic [1:0] addr_lo);
        return (addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the CPU memory port and mem_responder.
// The req_be lane enables exist only when MEM_RESP_BYTE_EN is defined.
interface mem_responder_if;

    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        resp_ready;
`ifdef MEM_RESP_BYTE_EN
    logic [3:0]  req_be;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
`else
    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
`endif

endinterface

// File: rtl/mem_resp_array.sv
// Single-port synchronous word storage with a registered read port.
// With MEM_RESP_BYTE_EN defined, writes honour per-byte lane enables;
// otherwise every write replaces the whole word.
module mem_resp_array #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
`ifdef MEM_RESP_BYTE_EN
    input  logic [3:0]        be,
`endif
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    // One access per enabled cycle: optional write plus a registered read of the same word.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
`ifdef MEM_RESP_BYTE_EN
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
`else
                mem[addr] <= wdata;
`endif
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one word request at a time, waits a
// programmable latency, services it from mem_resp_array and holds the
// response until the requester takes it.
// Optional feature macro: MEM_RESP_BYTE_EN (per-byte write enables).
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);

    localparam logic [MEM_RESP_LAT_W-1:0] CNT_INIT =
        (LATENCY >= 2) ? MEM_RESP_LAT_W'(LATENCY - 2) : '0;

    state_t                    state;
    state_t                    state_next;
    logic [MEM_RESP_LAT_W-1:0] cnt;
    logic [MEM_RESP_LAT_W-1:0] cnt_next;

    logic                      req_ready_q;
    logic                      resp_valid_q;
    logic                      resp_err_q;
    logic                      resp_is_rd;

    logic                      cap_we;
    logic [ADDR_W-1:0]         cap_addr;
    logic [31:0]               cap_wdata;
    logic                      cap_err;
`ifdef MEM_RESP_BYTE_EN
    logic [3:0]                cap_be;
`endif

    logic                      accept;
    logic                      access;
    logic                      handshake;
    logic [31:0]               arr_rdata;
    logic                      unused_addr_hi;

    // Address bits above the word index are deliberately ignored (wrap modulo DEPTH).
    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

    // The array is touched in the first RESP cycle; its edge is also where resp_valid rises.
    assign accept    = (state == IDLE) && bus.req_valid && req_ready_q;
    assign access    = (state == RESP) && !resp_valid_q;
    assign handshake = resp_valid_q && bus.resp_ready;

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_is_rd ? arr_rdata : 32'd0;

    // Next-state and latency counter logic.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            RESP: begin
                if (handshake) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; req_ready is registered so it rises one edge after reset or handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            req_ready_q <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            req_ready_q <= (state_next == IDLE);
        end
    end

    // Capture the request on the acceptance edge; later bus activity is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_err   <= 1'b0;
`ifdef MEM_RESP_BYTE_EN
            cap_be    <= '0;
`endif
        end else if (accept) begin
            cap_we    <= bus.req_we;
            cap_addr  <= bus.req_addr[ADDR_W+1:2];
            cap_wdata <= bus.req_wdata;
            cap_err   <= is_misaligned(bus.req_addr[1:0]);
`ifdef MEM_RESP_BYTE_EN
            cap_be    <= bus.req_be;
`endif
        end
    end

    // Response flags: set on the access edge, held until the handshake clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_is_rd   <= 1'b0;
        end else if (access) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= cap_err;
            resp_is_rd   <= !cap_we && !cap_err;
        end else if (handshake) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_is_rd   <= 1'b0;
        end
    end

    // Reset gates the enable so an aborted write can never reach the array.
    mem_resp_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .en    (access && !reset),
        .we    (cap_we && !cap_err),
`ifdef MEM_RESP_BYTE_EN
        .be    (cap_be),
`endif
        .addr  (cap_addr),
        .wdata (cap_wdata),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios followed by
// randomized transactions checked against a word-array reference model.
module tb_mem_responder;

    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;
    localparam int LAT    = 4;

    logic clk = 1'b0;
    logic reset;

    mem_responder_if bus ();

    mem_responder #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .LATENCY (LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference memory: word index -> contents; absent entries are zero.
    logic [31:0] model_mem [int];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int word_idx(input logic [31:0] addr);
        return int'((addr >> 2) % DEPTH);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        int idx;
        idx = word_idx(addr);
        return model_mem.exists(idx) ? model_mem[idx] : 32'd0;
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        logic [31:0] mask;
        logic [31:0] old;
        for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{be[i]}};
        old = model_read(addr);
        model_mem[word_idx(addr)] = (old & ~mask) | (wdata & mask);
    endtask

    // Garbage on the request lines to show they are ignored when not accepted.
    task automatic idle_inputs();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
`ifdef MEM_RESP_BYTE_EN
        bus.req_be    = 4'($urandom);
`endif
    endtask

    task automatic drive_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
`ifdef MEM_RESP_BYTE_EN
        bus.req_be    = be;
`else
        if (be != 4'hF) $display("[TB] note: lane enables ignored in this build");
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "/req_ready"},  {31'd0, bus.req_ready},  32'd0);
        check({tag, "/resp_valid"}, {31'd0, bus.resp_valid}, 32'd0);
        check({tag, "/resp_rdata"}, bus.resp_rdata,           32'd0);
        check({tag, "/resp_err"},   {31'd0, bus.resp_err},   32'd0);
    endtask

    // Full transaction with exact-cycle latency, optional backpressure and handshake checks.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input int hold, input bit early_ready,
                           input string tag);
        logic [31:0] exp_rdata;
        logic        exp_err;
        exp_err   = ((addr & 32'h3) != 0);
        exp_rdata = (!we && !exp_err) ? model_read(addr) : 32'd0;
        check({tag, "/ready_before"}, {31'd0, bus.req_ready}, 32'd1);
        drive_req(we, addr, wdata, be);
        bus.resp_ready = early_ready;
        tick();
        idle_inputs();
        if (we && !exp_err) model_write(addr, wdata, be);
        check({tag, "/valid_early"}, {31'd0, bus.resp_valid}, 32'd0);
        check({tag, "/ready_busy"},  {31'd0, bus.req_ready},  32'd0);
        for (int i = 1; i < LAT; i++) begin
            tick();
            check({tag, "/valid_early"}, {31'd0, bus.resp_valid}, 32'd0);
            check({tag, "/ready_busy"},  {31'd0, bus.req_ready},  32'd0);
        end
        tick();
        check({tag, "/valid"}, {31'd0, bus.resp_valid}, 32'd1);
        check({tag, "/err"},   {31'd0, bus.resp_err},   {31'd0, exp_err});
        check({tag, "/rdata"}, bus.resp_rdata,           exp_rdata);
        check({tag, "/ready_resp"}, {31'd0, bus.req_ready}, 32'd0);
        if (!early_ready) begin
            for (int h = 0; h < hold; h++) begin
                tick();
                check({tag, "/hold_valid"}, {31'd0, bus.resp_valid}, 32'd1);
                check({tag, "/hold_err"},   {31'd0, bus.resp_err},   {31'd0, exp_err});
                check({tag, "/hold_rdata"}, bus.resp_rdata,           exp_rdata);
                check({tag, "/hold_ready"}, {31'd0, bus.req_ready},  32'd0);
            end
            bus.resp_ready = 1'b1;
        end
        tick();
        bus.resp_ready = 1'b0;
        check({tag, "/valid_after"}, {31'd0, bus.resp_valid}, 32'd0);
        check({tag, "/ready_after"}, {31'd0, bus.req_ready},  32'd1);
    endtask

    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [3:0]  r_be;

    initial begin
        $display("[TB] mem_responder bench, LATENCY=%0d", LAT);
        bus.resp_ready = 1'b0;
        idle_inputs();

        // Reset held for three cycles, then release.
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_reset_outputs("reset");
        end
        reset = 1'b0;
        tick();
        check("release/req_ready",  {31'd0, bus.req_ready},  32'd1);
        check("release/resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        tick();
        check("idle/resp_valid",    {31'd0, bus.resp_valid}, 32'd0);

        // Write then read back.
        run_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b1, "wr10");
        run_txn(1'b0, 32'h10, 32'h0,        4'hF, 0, 1'b1, "rd10");

        // Backpressure for five cycles.
        run_txn(1'b0, 32'h10, 32'h0, 4'hF, 5, 1'b0, "bp");

        // Misaligned write must not disturb 0x10.
        run_txn(1'b1, 32'h13, 32'h1234, 4'hF, 0, 1'b1, "mis_wr");
        run_txn(1'b0, 32'h10, 32'h0,    4'hF, 0, 1'b1, "rd10_after_mis");
        check("rd10_model", model_read(32'h10), 32'hDEADBEEF);

        // Address wrap modulo DEPTH.
        run_txn(1'b1, 32'h1000, 32'hA5A5A5A5, 4'hF, 0, 1'b1, "wr1000");
        run_txn(1'b0, 32'h0,    32'h0,        4'hF, 0, 1'b1, "rd0_wrap");

        // Reset two cycles after accepting a write: the write is lost.
        run_txn(1'b1, 32'h20, 32'h0BADF00D, 4'hF, 0, 1'b1, "wr20");
        drive_req(1'b1, 32'h20, 32'h55, 4'hF);
        tick();
        idle_inputs();
        tick();
        reset = 1'b1;
        tick();
        check_reset_outputs("rst_wait");
        tick();
        check_reset_outputs("rst_wait_hold");
        reset = 1'b0;
        tick();
        check("rst_wait/req_ready", {31'd0, bus.req_ready}, 32'd1);
        for (int i = 0; i < LAT + 1; i++) begin
            tick();
            check("rst_wait/no_valid", {31'd0, bus.resp_valid}, 32'd0);
        end
        run_txn(1'b0, 32'h20, 32'h0, 4'hF, 0, 1'b1, "rd20_after_rst");

        // Reset on the very edge the write would commit.
        drive_req(1'b1, 32'h20, 32'h77, 4'hF);
        tick();
        idle_inputs();
        for (int i = 1; i < LAT; i++) tick();
        check("rst_commit/valid_before", {31'd0, bus.resp_valid}, 32'd0);
        reset = 1'b1;
        tick();
        check_reset_outputs("rst_commit");
        reset = 1'b0;
        tick();
        run_txn(1'b0, 32'h20, 32'h0, 4'hF, 0, 1'b1, "rd20_after_rst2");

        // Request and reset on the same edge: nothing is captured.
        drive_req(1'b1, 32'h20, 32'h99, 4'hF);
        reset = 1'b1;
        tick();
        idle_inputs();
        check_reset_outputs("rst_same");
        reset = 1'b0;
        tick();
        check("rst_same/req_ready", {31'd0, bus.req_ready}, 32'd1);
        for (int i = 0; i < LAT + 1; i++) begin
            tick();
            check("rst_same/no_valid", {31'd0, bus.resp_valid}, 32'd0);
        end
        run_txn(1'b0, 32'h20, 32'h0, 4'hF, 0, 1'b1, "rd20_after_rst3");

`ifdef MEM_RESP_BYTE_EN
        // Lane-masked write into a word never written before.
        run_txn(1'b1, 32'h40, 32'hFFFFFFFF, 4'b0101, 0, 1'b1, "be_wr40");
        run_txn(1'b0, 32'h40, 32'h0,        4'hF,    0, 1'b1, "be_rd40");
        check("be_model40", model_read(32'h40), 32'h00FF00FF);
        run_txn(1'b1, 32'h40, 32'h12345678, 4'b0000, 0, 1'b1, "be_noop");
        run_txn(1'b0, 32'h40, 32'h0,        4'hF,    0, 1'b1, "be_rd40_noop");
`endif

        // Randomized traffic over a small pre-written pool of words.
        for (int i = 0; i < 8; i++) begin
            run_txn(1'b1, 32'(i * 4), $urandom, 4'hF, 0, 1'b1, "prefill");
        end
        for (int t = 0; t < 40; t++) begin
            r_addr = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 7) * 4);
            if ($urandom_range(0, 5) == 0) r_addr = r_addr | 32'($urandom_range(1, 3));
            r_data = $urandom;
`ifdef MEM_RESP_BYTE_EN
            r_be = 4'($urandom);
`else
            r_be = 4'hF;
`endif
            run_txn(1'($urandom), r_addr, r_data, r_be, $urandom_range(0, 3),
                    1'($urandom), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
